// File: rtl/controlador_display_if.sv
// Handshake and display bus for controlador_display.
// master drives producto/valido; slave drives listo, an, seg, dp.
interface controlador_display_if #(
    parameter int ANCHO   = 16,
    parameter int DIGITOS = 8
);
    logic [ANCHO-1:0]   producto;
    logic               valido;
    logic               listo;
    logic [DIGITOS-1:0] an;
    logic [6:0]         seg;
    logic               dp;

    modport master (
        output producto, valido,
        input  listo, an, seg, dp
    );

    modport slave (
        input  producto, valido,
        output listo, an, seg, dp
    );
endinterface

// File: rtl/controlador_display.sv
// Signed product -> BCD (double dabble) -> 8-digit multiplexed 7-seg.
// Ports: clk, reset (async high), clk_dividido (scan ref), bus (slave).
module controlador_display #(
    parameter int ANCHO   = 16,
    parameter int DIGITOS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_dividido,
    controlador_display_if.slave bus
);

    typedef enum logic [1:0] {
        REPOSO,
        CONV,
        CARGA
    } estado_t;

    estado_t          estado;
    logic [ANCHO-1:0] mag;
    logic [19:0]      bcd;
    logic [4:0]       cuenta;
    logic             signo;

    logic [19:0]      disp_bcd;
    logic             disp_signo;

    logic             s1, s2, s3, paso;
    logic [2:0]       idx;

    logic [2:0]       n;
    logic [31:0]      disp_ext;
    logic [3:0]       digito;
    logic [6:0]       seg_nxt;

    // Two's complement abs; -32768 wraps to 16'h8000, which read
    // as unsigned is the correct magnitude 32768.
    logic [ANCHO-1:0] abs_in;
    assign abs_in = bus.producto[ANCHO-1] ? (~bus.producto + 1'b1)
                                          : bus.producto;

    function automatic logic [19:0] ajustar(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] codigo(input logic [3:0] d);
        logic [6:0] c;
        unique case (d)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = 7'h7F;
        endcase
        return c;
    endfunction

    // Conversion FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado     <= REPOSO;
            mag        <= '0;
            bcd        <= '0;
            cuenta     <= '0;
            signo      <= 1'b0;
            disp_bcd   <= '0;
            disp_signo <= 1'b0;
            bus.listo  <= 1'b1;
        end else begin
            unique case (estado)
                REPOSO: begin
                    if (bus.valido) begin
                        signo     <= bus.producto[ANCHO-1];
                        mag       <= abs_in;
                        bcd       <= '0;
                        cuenta    <= 5'd16;
                        bus.listo <= 1'b0;
                        estado    <= CONV;
                    end
                end
                CONV: begin
                    bcd    <= {ajustar(bcd)[18:0], mag[ANCHO-1]};
                    mag    <= mag << 1;
                    cuenta <= cuenta - 5'd1;
                    if (cuenta == 5'd1)
                        estado <= CARGA;
                end
                CARGA: begin
                    disp_bcd   <= bcd;
                    disp_signo <= signo;
                    bus.listo  <= 1'b1;
                    estado     <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end

    // Significant digit count, at least one
    always_comb begin
        n = 3'd1;
        for (int i = 1; i < 5; i++) begin
            if (disp_bcd[4*i +: 4] != 4'd0)
                n = 3'(i + 1);
        end
    end

    assign disp_ext = {12'h000, disp_bcd};
    assign digito   = disp_ext[{idx, 2'b00} +: 4];

    always_comb begin
        seg_nxt = 7'h7F;
        if (idx < n)
            seg_nxt = codigo(digito);
        else if (idx == n && disp_signo && disp_bcd != 20'd0)
            seg_nxt = 7'h3F;
    end

    // Scan: sync, edge detect, registered step pulse, output update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            paso    <= 1'b0;
            idx     <= 3'd0;
            bus.an  <= '1;
            bus.seg <= 7'h7F;
        end else begin
            s1   <= clk_dividido;
            s2   <= s1;
            s3   <= s2;
            paso <= s2 & ~s3;
            if (paso) begin
                bus.an  <= ~(DIGITOS'(1) << idx);
                bus.seg <= seg_nxt;
                idx     <= idx + 3'd1;
            end
        end
    end

    assign bus.dp = 1'b1;

endmodule

// File: tb/tb_controlador_display.sv
// Directed table-driven bench for controlador_display.
// Checks reset, conversion latency, scan order and digit codes.
module tb_controlador_display;

    logic clk;
    logic reset;
    logic clk_dividido;

    controlador_display_if #(.ANCHO(16), .DIGITOS(8)) bus ();

    controlador_display #(.ANCHO(16), .DIGITOS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_dividido (clk_dividido),
        .bus          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     p;
        logic [7:0][6:0] s;
        string           nombre;
    } vec_t;

    vec_t vecs [6];

    int nchk;
    int nfail;
    int idx_tb;

    task automatic chk(input string nom, input logic [31:0] act,
                       input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nom, act, req);
        end
    endtask

    // One clk_dividido period, then check the digit that lit up
    task automatic paso_scan(input string nom, input logic [7:0][6:0] s);
        logic [7:0] an_req;
        clk_dividido = 1'b1;
        repeat (5) @(posedge clk);
        clk_dividido = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        an_req = ~(8'b1 << idx_tb);
        chk($sformatf("%s an d%0d", nom, idx_tb), 32'(bus.an), 32'(an_req));
        chk($sformatf("%s seg d%0d", nom, idx_tb), 32'(bus.seg),
            32'(s[idx_tb]));
        idx_tb = (idx_tb + 1) % 8;
    endtask

    task automatic scan8(input string nom, input logic [7:0][6:0] s);
        for (int k = 0; k < 8; k++)
            paso_scan(nom, s);
    endtask

    task automatic esperar_listo(input string nom);
        int c;
        c = 0;
        while (bus.listo !== 1'b1 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 100)
            chk({nom, " listo timeout"}, 32'(bus.listo), 32'd1);
    endtask

    // Pulse valido for one edge; returns with #1 after the accept edge
    task automatic lanzar(input logic [15:0] p);
        @(negedge clk);
        bus.producto = p;
        bus.valido   = 1'b1;
        @(posedge clk);
        #1;
        bus.valido   = 1'b0;
    endtask

    task automatic contar_ocupado(input string nom);
        int c;
        c = 0;
        while (bus.listo !== 1'b1 && c < 100) begin
            c++;
            @(posedge clk);
            #1;
        end
        chk({nom, " listo low cycles"}, 32'(c), 32'd17);
    endtask

    initial begin
        nchk         = 0;
        nfail        = 0;
        idx_tb       = 0;
        reset        = 1'b1;
        clk_dividido = 1'b0;
        bus.producto = '0;
        bus.valido   = 1'b0;

        vecs[0] = '{16'hFFD3,
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h19, 7'h12},
            "neg45"};
        vecs[1] = '{16'h8000,
            {7'h7F, 7'h7F, 7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00},
            "min"};
        vecs[2] = '{16'hFFF9,
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h78},
            "neg7"};
        vecs[3] = '{16'h0000,
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
            "zero"};
        vecs[4] = '{16'd100,
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40},
            "p100"};
        vecs[5] = '{16'd9,
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10},
            "p9"};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst an", 32'(bus.an), 32'hFF);
        chk("rst seg", 32'(bus.seg), 32'h7F);
        chk("rst dp", 32'(bus.dp), 32'd1);
        chk("rst listo", 32'(bus.listo), 32'd1);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("idle an", 32'(bus.an), 32'hFF);
        scan8("scan0", vecs[3].s);
        paso_scan("wrap", vecs[3].s);

        // Table: convert, check busy time, scan a full frame
        for (int v = 0; v < 6; v++) begin
            esperar_listo(vecs[v].nombre);
            lanzar(vecs[v].p);
            contar_ocupado(vecs[v].nombre);
            scan8(vecs[v].nombre, vecs[v].s);
        end

        // Strobe during conversion is dropped
        esperar_listo("drop");
        lanzar(16'd12345);
        repeat (4) @(posedge clk);
        #1;
        bus.producto = 16'd99;
        bus.valido   = 1'b1;
        @(posedge clk);
        #1;
        bus.valido   = 1'b0;
        begin
            int c;
            c = 5;
            while (bus.listo !== 1'b1 && c < 100) begin
                c++;
                @(posedge clk);
                #1;
            end
            chk("drop listo low cycles", 32'(c), 32'd17);
        end
        scan8("p12345",
            {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});

        // Reset in the middle of a conversion
        lanzar(16'd32767);
        repeat (7) @(posedge clk);
        #1;
        chk("pre-reset listo", 32'(bus.listo), 32'd0);
        reset = 1'b1;
        #1;
        chk("midrst listo", 32'(bus.listo), 32'd1);
        chk("midrst an", 32'(bus.an), 32'hFF);
        chk("midrst seg", 32'(bus.seg), 32'h7F);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        idx_tb = 0;
        scan8("after rst", vecs[3].s);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
